// File: rtl/lock_controller.sv
// Keypad lock sequencer: pops 8-bit codes from a FIFO, compares a full entry against
// the stored password, then opens for a fixed time or locks out after repeated failures.
module lock_controller #(
    parameter int PASSWORD_WIDTH = 4,
    parameter int MAX_ATTEMPTS   = 3,
    parameter int LOCKOUT_CYCLES = 1000,
    parameter int UNLOCK_CYCLES  = 100
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  empty,
    input  logic [7:0]                            code,
    input  logic [PASSWORD_WIDTH-1:0][7:0]        password,
    output logic                                  rd_en,
    output logic [PASSWORD_WIDTH-1:0]             leds,
    output logic                                  unlocked,
    output logic                                  locked_out,
    output logic [$clog2(MAX_ATTEMPTS+1)-1:0]     fail_cnt
);

    localparam int FW   = $clog2(MAX_ATTEMPTS + 1);
    localparam int TMAX = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ? LOCKOUT_CYCLES : UNLOCK_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int IW   = (PASSWORD_WIDTH > 1) ? $clog2(PASSWORD_WIDTH) : 1;

    localparam logic [TW-1:0] UNLOCK_LOAD  = TW'(UNLOCK_CYCLES - 1);
    localparam logic [TW-1:0] LOCKOUT_LOAD = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [IW-1:0] LAST_IDX     = IW'(PASSWORD_WIDTH - 1);
    localparam logic [FW-1:0] FAIL_MAX     = FW'(MAX_ATTEMPTS);
    localparam logic [7:0]    ESC_CODE     = 8'h1B;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CHECK,
        S_EVAL,
        S_OPEN,
        S_LOCKOUT
    } state_t;

    state_t                    state_q, state_d;
    logic [IW-1:0]             index_q, index_d;
    logic                      mismatch_q, mismatch_d;
    logic [PASSWORD_WIDTH-1:0] leds_q, leds_d;
    logic [FW-1:0]             fail_q, fail_d;
    logic [FW-1:0]             fail_inc;
    logic [TW-1:0]             timer_q, timer_d;
    logic [7:0]                code_q, code_d;
    logic                      unlocked_q, unlocked_d;
    logic                      locked_q, locked_d;
    logic                      init_q;

    // init_q holds off the first pop until one edge after reset release
    assign rd_en = init_q && !empty && ((state_q == S_IDLE) || (state_q == S_LOCKOUT));

    assign fail_inc = (fail_q == FAIL_MAX) ? fail_q : fail_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        mismatch_d = mismatch_q;
        leds_d     = leds_q;
        fail_d     = fail_q;
        timer_d    = timer_q;
        code_d     = code_q;

        case (state_q)
            S_IDLE: begin
                if (init_q && !empty) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                code_d  = code;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (code_q == ESC_CODE) begin
                    index_d    = '0;
                    mismatch_d = 1'b0;
                    leds_d     = '0;
                    state_d    = S_IDLE;
                end else begin
                    // keep consuming the whole entry so a wrong digit gives no positional hint
                    if (code_q != password[index_q]) begin
                        mismatch_d = 1'b1;
                    end
                    leds_d[index_q] = 1'b1;
                    index_d         = index_q + 1'b1;
                    state_d         = (index_q == LAST_IDX) ? S_EVAL : S_IDLE;
                end
            end
            S_EVAL: begin
                index_d    = '0;
                mismatch_d = 1'b0;
                leds_d     = '0;
                if (!mismatch_q) begin
                    fail_d  = '0;
                    timer_d = UNLOCK_LOAD;
                    state_d = S_OPEN;
                end else begin
                    fail_d = fail_inc;
                    if (fail_inc == FAIL_MAX) begin
                        timer_d = LOCKOUT_LOAD;
                        state_d = S_LOCKOUT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_OPEN: begin
                if (timer_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_LOCKOUT: begin
                if (timer_q == '0) begin
                    fail_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // status flags track the next state so they are high for exactly the dwell time
        unlocked_d = (state_d == S_OPEN);
        locked_d   = (state_d == S_LOCKOUT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            index_q    <= '0;
            mismatch_q <= 1'b0;
            leds_q     <= '0;
            fail_q     <= '0;
            timer_q    <= '0;
            code_q     <= '0;
            unlocked_q <= 1'b0;
            locked_q   <= 1'b0;
            init_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            mismatch_q <= mismatch_d;
            leds_q     <= leds_d;
            fail_q     <= fail_d;
            timer_q    <= timer_d;
            code_q     <= code_d;
            unlocked_q <= unlocked_d;
            locked_q   <= locked_d;
            init_q     <= 1'b1;
        end
    end

    assign leds       = leds_q;
    assign unlocked   = unlocked_q;
    assign locked_out = locked_q;
    assign fail_cnt   = fail_q;

endmodule
